// File: rtl/mac_seq_ctrl.sv
// Sequencer driving a single MAC processing element through C = A x B (row-major).
// Issues 1-cycle-latency SRAM reads, controls PE clear/valid, and streams results over valid/ready.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DIM_WIDTH-1:0]    m_i,
  input  logic [DIM_WIDTH-1:0]    n_i,
  input  logic [DIM_WIDTH-1:0]    k_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    a_req_o,
  output logic [ADDR_WIDTH-1:0]   a_addr_o,
  output logic                    b_req_o,
  output logic [ADDR_WIDTH-1:0]   b_addr_o,
  output logic                    pe_a_valid_o,
  output logic                    pe_b_valid_o,
  output logic                    pe_acc_clr_o,
  input  logic [2*DATA_WIDTH-1:0] pe_acc_i,
  output logic                    c_valid_o,
  input  logic                    c_ready_i,
  output logic [ADDR_WIDTH-1:0]   c_addr_o,
  output logic [2*DATA_WIDTH-1:0] c_data_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]            state;
  logic [DIM_WIDTH-1:0]  m_dim, n_dim, k_dim;
  logic [DIM_WIDTH-1:0]  m, n, k;
  logic [ADDR_WIDTH-1:0] a_row;   // m*K
  logic [ADDR_WIDTH-1:0] a_ptr;   // m*K + k
  logic [ADDR_WIDTH-1:0] b_ptr;   // k*N + n
  logic [ADDR_WIDTH-1:0] c_ptr;   // m*N + n
  logic                  pe_valid;

  logic [ADDR_WIDTH-1:0] k_step, n_step, a_next_row;
  logic                  last_k, last_n, last_m;

  assign k_step     = ADDR_WIDTH'(k_dim);
  assign n_step     = ADDR_WIDTH'(n_dim);
  assign a_next_row = a_row + k_step;
  assign last_k     = (k == k_dim - DIM_WIDTH'(1));
  assign last_n     = (n == n_dim - DIM_WIDTH'(1));
  assign last_m     = (m == m_dim - DIM_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      m_dim    <= '0;
      n_dim    <= '0;
      k_dim    <= '0;
      m        <= '0;
      n        <= '0;
      k        <= '0;
      a_row    <= '0;
      a_ptr    <= '0;
      b_ptr    <= '0;
      c_ptr    <= '0;
      pe_valid <= 1'b0;
    end else begin
      // Read data arrives one cycle after the request, so the PE valid trails it by one.
      pe_valid <= (state == FEED);
      case (state)
        IDLE: begin
          if (start_i) begin
            if (m_i != '0 && n_i != '0 && k_i != '0) begin
              m_dim <= m_i;
              n_dim <= n_i;
              k_dim <= k_i;
              m     <= '0;
              n     <= '0;
              k     <= '0;
              a_row <= '0;
              a_ptr <= '0;
              b_ptr <= '0;
              c_ptr <= '0;
              state <= CLEAR;
            end else begin
              state <= DONE;
            end
          end
        end
        CLEAR: state <= FEED;
        FEED: begin
          a_ptr <= a_ptr + ADDR_WIDTH'(1);
          b_ptr <= b_ptr + n_step;
          if (last_k) begin
            k     <= '0;
            state <= DRAIN;
          end else begin
            k <= k + DIM_WIDTH'(1);
          end
        end
        DRAIN: state <= WRITE;
        WRITE: begin
          if (c_ready_i) begin
            c_ptr <= c_ptr + ADDR_WIDTH'(1);
            // Rewind the operand pointers to the start of the next element's row/column.
            if (last_n) begin
              n     <= '0;
              m     <= m + DIM_WIDTH'(1);
              a_row <= a_next_row;
              a_ptr <= a_next_row;
              b_ptr <= '0;
              state <= last_m ? DONE : CLEAR;
            end else begin
              n     <= n + DIM_WIDTH'(1);
              a_ptr <= a_row;
              b_ptr <= ADDR_WIDTH'(n) + ADDR_WIDTH'(1);
              state <= CLEAR;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign a_req_o      = (state == FEED);
  assign b_req_o      = a_req_o;
  assign a_addr_o     = (state == FEED) ? a_ptr : '0;
  assign b_addr_o     = (state == FEED) ? b_ptr : '0;
  assign pe_a_valid_o = pe_valid;
  assign pe_b_valid_o = pe_valid;
  assign pe_acc_clr_o = (state == CLEAR);
  assign c_valid_o    = (state == WRITE);
  assign c_addr_o     = (state == WRITE) ? c_ptr : '0;
  assign c_data_o     = (state == WRITE) ? pe_acc_i : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl with behavioural operand SRAMs and a MAC PE model.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, c_ready;
  logic [7:0]  m_in, n_in, k_in;
  logic        busy, done, a_req, b_req, pva, pvb, clr, c_valid;
  logic [15:0] a_addr, b_addr, c_addr;
  logic [31:0] pe_acc, c_data;

  mac_seq_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DIM_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .m_i(m_in), .n_i(n_in), .k_i(k_in),
    .busy_o(busy), .done_o(done),
    .a_req_o(a_req), .a_addr_o(a_addr), .b_req_o(b_req), .b_addr_o(b_addr),
    .pe_a_valid_o(pva), .pe_b_valid_o(pvb), .pe_acc_clr_o(clr), .pe_acc_i(pe_acc),
    .c_valid_o(c_valid), .c_ready_i(c_ready), .c_addr_o(c_addr), .c_data_o(c_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand SRAMs (1-cycle latency) and PE; the PE is deliberately not reset.
  logic [15:0] amem [16];
  logic [15:0] bmem [16];
  logic [15:0] a_rd, b_rd;
  logic [31:0] acc = '0;
  always @(posedge clk) begin
    if (a_req) a_rd <= amem[a_addr[3:0]];
    if (b_req) b_rd <= bmem[b_addr[3:0]];
    if (clr) acc <= '0;
    else if (pva && pvb) acc <= acc + a_rd * b_rd;
  end
  assign pe_acc = acc;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [15:0] a_seen[$];
  logic [15:0] b_seen[$];
  logic        any_act;
  int unsigned start_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake, checks PE interface rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_req) begin
        a_seen.push_back(a_addr);
        b_seen.push_back(b_addr);
      end
      if (a_req || c_valid) any_act = 1'b1;
      chk("b_req_eq_a_req", b_req, a_req);
      chk("clr_valid_excl", clr && (pva || pvb), 1'b0);
      if (c_valid && c_ready) begin
        if (exp_addr.size() == 0) begin
          chk("unexpected_write", 1'b1, 1'b0);
        end else begin
          chk("c_addr", c_addr, exp_addr.pop_front());
          chk("c_data", c_data, exp_data.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic load_2x2x3();
    for (int i = 0; i < 6; i++) begin
      amem[i] = 16'(i + 1);
      bmem[i] = 16'(i + 7);
    end
  endtask

  task automatic push_2x2x3();
    push_exp(16'd0, 32'd58);
    push_exp(16'd1, 32'd64);
    push_exp(16'd2, 32'd139);
    push_exp(16'd3, 32'd154);
  endtask

  // Called #1 after a clock edge while the DUT is in IDLE.
  task automatic issue(input int m, input int n, input int k);
    start = 1'b1;
    m_in = 8'(m); n_in = 8'(n); k_in = 8'(k);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    m_in = 8'hEE; n_in = 8'hDD; k_in = 8'hCC;
  endtask

  task automatic wait_done(input int exp_lat, input bit pulse);
    int budget = 300;
    while (!done && budget > 0) begin
      if (pulse) begin
        start = cyc[0];
        m_in = 8'($urandom_range(0, 5)); n_in = 8'($urandom_range(0, 5)); k_in = 8'($urandom_range(0, 5));
      end
      @(posedge clk); #1;
      budget--;
    end
    start = 1'b0;
    if (budget == 0) chk("done_timeout", 1'b0, 1'b1);
    else chk("done_latency", 64'(cyc - start_cyc), 64'(exp_lat));
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    chk("scoreboard_empty", 64'(exp_addr.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_reqs"}, {a_req, b_req, pva, pvb, clr, c_valid}, 6'd0);
    chk({tag, "_a_addr"}, a_addr, 16'd0);
    chk({tag, "_b_addr"}, b_addr, 16'd0);
    chk({tag, "_c_addr"}, c_addr, 16'd0);
    chk({tag, "_c_data"}, c_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; c_ready = 1'b1;
    m_in = '0; n_in = '0; k_in = '0;
    any_act = 1'b0;
    for (int i = 0; i < 16; i++) begin amem[i] = '0; bmem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1x1x1: 3*5
    amem[0] = 16'd3; bmem[0] = 16'd5;
    push_exp(16'd0, 32'd15);
    issue(1, 1, 1);
    wait_done(5, 1'b0);

    // 2x2x3 with continuous ready, address sequence capture
    load_2x2x3();
    push_2x2x3();
    a_seen.delete(); b_seen.delete();
    issue(2, 2, 3);
    wait_done(25, 1'b0);
    chk("req_count", 64'(a_seen.size()), 64'd12);
    if (a_seen.size() == 12) begin
      chk("a_addr_e0_0", a_seen[0], 16'd0);
      chk("a_addr_e0_1", a_seen[1], 16'd1);
      chk("a_addr_e0_2", a_seen[2], 16'd2);
      chk("b_addr_e0_0", b_seen[0], 16'd0);
      chk("b_addr_e0_1", b_seen[1], 16'd2);
      chk("b_addr_e0_2", b_seen[2], 16'd4);
      chk("b_addr_e1_0", b_seen[3], 16'd1);
      chk("b_addr_e1_2", b_seen[5], 16'd5);
      chk("a_addr_e2_0", a_seen[6], 16'd3);
      chk("a_addr_e2_2", a_seen[8], 16'd5);
      chk("b_addr_e3_1", b_seen[10], 16'd3);
    end

    // Back-pressure at the first WRITE for 5 cycles
    push_2x2x3();
    c_ready = 1'b0;
    issue(2, 2, 3);
    begin
      int budget = 50;
      while (!c_valid && budget > 0) begin @(posedge clk); #1; budget--; end
      chk("stall_reach_write", c_valid, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", c_valid, 1'b1);
      chk("stall_addr", c_addr, 16'd0);
      chk("stall_data", c_data, 32'd58);
      chk("stall_no_req", a_req, 1'b0);
      @(posedge clk); #1;
    end
    chk("stall_still_valid", c_valid, 1'b1);
    c_ready = 1'b1;
    wait_done(30, 1'b0);

    // Zero inner dimension: straight to DONE
    any_act = 1'b0;
    issue(2, 2, 0);
    wait_done(1, 1'b0);
    chk("k0_no_activity", any_act, 1'b0);

    // Spurious start pulses and dimension changes mid-run
    push_2x2x3();
    issue(2, 2, 3);
    wait_done(25, 1'b1);

    // Reset during FEED of element 1
    push_exp(16'd0, 32'd58);
    issue(2, 2, 3);
    repeat (7) @(posedge clk);
    #1;
    chk("e1_feed_req", a_req, 1'b1);
    chk("e1_feed_b_addr", b_addr, 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle("midrst");
    rst = 1'b0;
    any_act = 1'b0;
    begin
      bit saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (done) saw_done = 1'b1;
        @(posedge clk); #1;
      end
      chk("midrst_no_done", saw_done, 1'b0);
    end
    chk("midrst_quiet", any_act, 1'b0);
    chk("midrst_scoreboard", 64'(exp_addr.size()), 64'd0);

    push_2x2x3();
    issue(2, 2, 3);
    wait_done(25, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
